qnigma_math_chacha20_xor: RTL and testbench
===========================================

QNIGMA_MATH_CHACHA20_XOR -- requirements
Module: qnigma_math_chacha20_xor

Interface
REQ-001 SHALL have parameter KST_W, default KST_RAM_WIDTH (qnigma_chacha20_pkg), keystream word width in bits, multiple of 8, divides 512.
REQ-002 SHALL have parameter BLK_WRDS, default 512/KST_W, keystream words per ChaCha20 block.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 kst_rdy  input  1  keystream buffer holds at least one word.
REQ-006 kst_read  output  1  one-cycle pulse requesting one keystream word.
REQ-007 kst_str  input  KST_W  keystream word, valid exactly 1 cycle after kst_read.
REQ-008 in_val / in_dat / in_lst  input  1/8/1  plaintext/ciphertext byte stream; in_lst marks last byte of message.
REQ-009 in_rdy  output  1  byte accepted when in_val && in_rdy.
REQ-010 out_val / out_dat / out_lst  output  1/8/1  XORed byte stream; out_lst mirrors in_lst.
REQ-011 out_rdy  input  1  downstream accepts when out_val && out_rdy.

Function
REQ-012 SHALL implement FSM states EMPTY, WAIT, FULL, DISC (DISC only with macro, REQ-031).
REQ-013 EMPTY: when kst_rdy, assert kst_read for one cycle, go WAIT; else stay; kst_read never asserted outside EMPTY/DISC.
REQ-014 WAIT: capture kst_str into word register kw, byte_idx<=0, go FULL.
REQ-015 FULL: in_rdy = !out_val || out_rdy; in_rdy=0 in all other states.
REQ-016 On accept: out_dat <= in_dat ^ kw[8*byte_idx +: 8] (least significant byte first), out_lst <= in_lst, out_val <= 1, byte_idx++.
REQ-017 Latency: accepted byte appears on out_* next cycle; full throughput 1 byte/cycle while in FULL and out_rdy held high.
REQ-018 out_val SHALL clear when out_rdy && no new accept; out_* SHALL hold stable while out_val && !out_rdy.
REQ-019 Accepted byte with byte_idx == KST_W/8-1: go EMPTY; wrd_idx <= wrd_idx+1 mod BLK_WRDS.
REQ-020 wrd_idx (log2(BLK_WRDS) bits) counts keystream words consumed within current block; wraps BLK_WRDS-1 -> 0.
REQ-021 Gap between words: last byte of a word to first byte of next word SHALL be >= 2 idle cycles (EMPTY, WAIT); no keystream byte reused or skipped except per REQ-031.
REQ-022 kst_rdy low in EMPTY: stall indefinitely, in_rdy=0, out_* drain normally.
REQ-023 in_lst without macro: no special action; leftover bytes of kw serve next message contiguously.
REQ-024 kst_str ignored in all cycles except WAIT.

Reset
REQ-025 On rst: state EMPTY, kst_read=0, in_rdy=0, out_val=0, out_lst=0, out_dat=0, kw=0, byte_idx=0, wrd_idx=0.
REQ-026 rst mid-operation (any state) SHALL abort in-flight byte and pending kst read; kst_str arriving the cycle after rst is discarded.
REQ-027 Reset SHALL be applied together with the keystream buffer reset so both ends realign to word 0.

Configuration
REQ-028 Macro QNIGMA_CHACHA20_XOR_BLK_ALIGN_EN selects per-message block alignment.
REQ-029 Undefined: REQ-023 applies; DISC state and its logic absent.
REQ-030 Defined: each message SHALL start at byte 0 of word 0 of a fresh keystream block.
REQ-031 Defined: on accepting in_lst byte, remaining bytes of kw discarded; if new wrd_idx != 0, enter DISC: pulse kst_read once per word when kst_rdy (one read per 2 cycles, data dropped), wrd_idx++ per read, exit to EMPTY when wrd_idx wraps to 0; if already 0, go EMPTY.
REQ-032 Defined: in_rdy=0 throughout DISC.

Verification (KST_W=32)
REQ-033 kst word 0x03020100; bytes AA,BB,CC,DD -> out AA,BA,CE,DE, 1-cycle latency, one kst_read.
REQ-034 8 bytes, out_rdy=1, kst_rdy=1 -> exactly 2 kst_read pulses, 2-cycle gap after byte 4, no data loss.
REQ-035 out_rdy low 3 cycles mid-word -> out_dat held, in_rdy=0, resumes with next byte XORed by next keystream byte.
REQ-036 Macro defined, 5-byte message with in_lst -> 16 kst_read total (2 used, 14 in DISC), next message first byte XORed with byte 0 of next block; macro undefined -> 2 reads, next message uses byte 1 of word 1.
REQ-037 kst_rdy=0 for 10 cycles in EMPTY then 1 -> no kst_read, in_rdy=0 during stall; rst asserted in WAIT -> all outputs 0 next cycle, state EMPTY.

Source files
------------

// File: rtl/qnigma_math_chacha20_xor.sv
// ChaCha20 keystream XOR stage.
// Pulls keystream words from a buffer one at a time and XORs them byte by byte,
// least significant byte first, onto a byte stream. Each output byte appears
// one cycle after it is accepted.
// Build option: QNIGMA_CHACHA20_XOR_BLK_ALIGN_EN. When it is defined, every
// message starts on a fresh keystream block. The rest of the block after the
// last byte of a message is read from the buffer and dropped.
//
// state | meaning
// EMPTY | no keystream word held; request one when the buffer has data
// WAIT  | read in flight; kst_str is valid this cycle and gets captured
// FULL  | word held; XOR incoming bytes with it
// DISC  | (align build only) read and drop words until the block wraps

package qnigma_chacha20_pkg;
  localparam int KST_RAM_WIDTH = 32;
endpackage

module qnigma_math_chacha20_xor
  import qnigma_chacha20_pkg::*;
#(
  parameter int KST_W    = KST_RAM_WIDTH,
  parameter int BLK_WRDS = 512 / KST_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kst_rdy,
  output logic             kst_read,
  input  logic [KST_W-1:0] kst_str,
  input  logic             in_val,
  input  logic [7:0]       in_dat,
  input  logic             in_lst,
  output logic             in_rdy,
  output logic             out_val,
  output logic [7:0]       out_dat,
  output logic             out_lst,
  input  logic             out_rdy
);

  localparam int BYTES = KST_W / 8;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WI_W  = (BLK_WRDS > 1) ? $clog2(BLK_WRDS) : 1;
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(BYTES - 1);
  localparam logic [WI_W-1:0] WI_LAST = WI_W'(BLK_WRDS - 1);

`ifdef QNIGMA_CHACHA20_XOR_BLK_ALIGN_EN
  typedef enum logic [1:0] {EMPTY, WAIT, FULL, DISC} state_t;
`else
  typedef enum logic [1:0] {EMPTY, WAIT, FULL} state_t;
`endif

  state_t           state, state_nxt;
  logic [KST_W-1:0] kw;
  logic [BI_W-1:0]  byte_idx;
  logic [WI_W-1:0]  wrd_idx, wrd_idx_inc;
  logic [7:0]       kw_byte;
  logic             accept;
  logic             wrd_done;
`ifdef QNIGMA_CHACHA20_XOR_BLK_ALIGN_EN
  // Set in the cycle after a discard read, so that DISC reads at most every other cycle.
  logic             disc_ph;
`endif

  assign accept      = in_val && in_rdy;
  assign kw_byte     = kw[{byte_idx, 3'b000} +: 8];
  assign wrd_idx_inc = (wrd_idx == WI_LAST) ? '0 : wrd_idx + WI_W'(1);
`ifdef QNIGMA_CHACHA20_XOR_BLK_ALIGN_EN
  assign wrd_done    = accept && ((byte_idx == BI_LAST) || in_lst);
`else
  assign wrd_done    = accept && (byte_idx == BI_LAST);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (kst_rdy) state_nxt = WAIT;
      WAIT:  state_nxt = FULL;
      FULL: begin
        if (accept) begin
`ifdef QNIGMA_CHACHA20_XOR_BLK_ALIGN_EN
          if (in_lst) state_nxt = (wrd_idx_inc != '0) ? DISC : EMPTY;
          else
`endif
          if (byte_idx == BI_LAST) state_nxt = EMPTY;
        end
      end
`ifdef QNIGMA_CHACHA20_XOR_BLK_ALIGN_EN
      DISC: if (kst_read && (wrd_idx == WI_LAST)) state_nxt = EMPTY;
`endif
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake outputs; held low while rst is asserted, so no read or accept can start during reset
  always_comb begin
    kst_read = 1'b0;
    in_rdy   = 1'b0;
    if (!rst) begin
      case (state)
        EMPTY: kst_read = kst_rdy;
        FULL:  in_rdy   = !out_val || out_rdy;
`ifdef QNIGMA_CHACHA20_XOR_BLK_ALIGN_EN
        DISC:  kst_read = kst_rdy && !disc_ph;
`endif
        default: ;
      endcase
    end
  end

  // Datapath: keystream word capture, byte XOR, output register, word/block counters
  always_ff @(posedge clk) begin
    if (rst) begin
      out_val  <= 1'b0;
      out_dat  <= '0;
      out_lst  <= 1'b0;
      kw       <= '0;
      byte_idx <= '0;
      wrd_idx  <= '0;
`ifdef QNIGMA_CHACHA20_XOR_BLK_ALIGN_EN
      disc_ph  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        out_val  <= 1'b1;
        out_dat  <= in_dat ^ kw_byte;
        out_lst  <= in_lst;
        byte_idx <= byte_idx + BI_W'(1);
      end else if (out_rdy) begin
        out_val  <= 1'b0;
      end
      if (state == WAIT) begin
        kw       <= kst_str;
        byte_idx <= '0;
      end
      if (wrd_done) wrd_idx <= wrd_idx_inc;
`ifdef QNIGMA_CHACHA20_XOR_BLK_ALIGN_EN
      disc_ph <= (state == DISC) && kst_read;
      if ((state == DISC) && kst_read) wrd_idx <= wrd_idx_inc;
`endif
    end
  end

endmodule

// File: tb/tb_qnigma_math_chacha20_xor.sv
// Directed bench for qnigma_math_chacha20_xor (KST_W = 32).
// A keystream buffer model returns word n = {4n+3, 4n+2, 4n+1, 4n}, so stream
// byte p equals p mod 256. A scoreboard queue holds the expected output bytes.
module tb_qnigma_math_chacha20_xor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        kst_rdy = 1'b0;
  logic        kst_read;
  logic [31:0] kst_str = '0;
  logic        in_val = 1'b0;
  logic [7:0]  in_dat = '0;
  logic        in_lst = 1'b0;
  logic        in_rdy;
  logic        out_val;
  logic [7:0]  out_dat;
  logic        out_lst;
  logic        out_rdy = 1'b1;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          model_pos = 0;
  logic [8:0]  sb_q[$];
  int          c[8];
  int          dummy;

  qnigma_math_chacha20_xor #(.KST_W(32), .BLK_WRDS(16)) dut (
    .clk(clk), .rst(rst), .kst_rdy(kst_rdy), .kst_read(kst_read), .kst_str(kst_str),
    .in_val(in_val), .in_dat(in_dat), .in_lst(in_lst), .in_rdy(in_rdy),
    .out_val(out_val), .out_dat(out_dat), .out_lst(out_lst), .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ks_byte(input int p);
    return 8'(p);
  endfunction

  function automatic logic [31:0] ks_word(input int n);
    return {ks_byte(4*n+3), ks_byte(4*n+2), ks_byte(4*n+1), ks_byte(4*n)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Keystream buffer model. It returns the requested word one cycle after kst_read and random data otherwise.
  always @(posedge clk) begin
    if (rst) rd_cnt <= 0;
    else if (kst_read) rd_cnt <= rd_cnt + 1;
    if (!rst && kst_read) kst_str <= ks_word(rd_cnt);
    else                  kst_str <= $urandom;
  end

  // Output monitor. It pops an expected byte for each completed output transfer.
  always @(negedge clk) begin
    if (!rst && out_val === 1'b1 && out_rdy) begin
      if (sb_q.size() == 0) check("unexpected_out", sb_q.size(), 1);
      else check("out_byte", {23'b0, out_lst, out_dat}, {23'b0, sb_q.pop_front()});
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    in_val = 1'b1; in_dat = d; in_lst = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_rdy) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", {31'b0, ok}, 1);
    acc_cyc = cyc;
    if (ok) begin
      sb_q.push_back({l, d ^ ks_byte(model_pos)});
      model_pos++;
`ifdef QNIGMA_CHACHA20_XOR_BLK_ALIGN_EN
      if (l) model_pos = ((model_pos + 63) / 64) * 64;
`endif
    end
    @(posedge clk); #1;
    in_val = 1'b0; in_lst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", sb_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_val = 1'b0; in_lst = 1'b0; kst_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    model_pos = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_kst_read", {31'b0, kst_read}, 0);
    check("rst_in_rdy",   {31'b0, in_rdy}, 0);
    check("rst_out_val",  {31'b0, out_val}, 0);
    check("rst_out_dat",  {24'b0, out_dat}, 0);
    check("rst_out_lst",  {31'b0, out_lst}, 0);

    // One word: AA,BB,CC,DD XOR 0x03020100, with 1-cycle latency and one read
    @(posedge clk); #1;
    kst_rdy = 1'b1; out_rdy = 1'b1;
    send_byte(8'hAA, 1'b0, dummy);
    check("lat_out_val", {31'b0, out_val}, 1);
    check("lat_out_dat", {24'b0, out_dat}, 32'hAA);
    send_byte(8'hBB, 1'b0, dummy);
    send_byte(8'hCC, 1'b0, dummy);
    send_byte(8'hDD, 1'b0, dummy);
    check("w0_last_dat", {24'b0, out_dat}, 32'hDE);
    check("w0_reads", rd_cnt, 1);
    drain();

    // Eight bytes at full rate: two reads and a 2-cycle gap between words
    do_reset();
    kst_rdy = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b0, c[i]);
    check("thru_b0_b1", c[1] - c[0], 1);
    check("thru_b2_b3", c[3] - c[2], 1);
    check("gap_b3_b4",  c[4] - c[3], 3);
    check("thru_b4_b7", c[7] - c[4], 3);
    check("two_reads",  rd_cnt, 2);
    drain();

    // Downstream stall in the middle of a word
    do_reset();
    kst_rdy = 1'b1;
    send_byte(8'h21, 1'b0, dummy);
    send_byte(8'h22, 1'b0, dummy);
    out_rdy = 1'b0;
    in_val = 1'b1; in_dat = 8'h23;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_rdy",  {31'b0, in_rdy}, 0);
      check("stall_out_val", {31'b0, out_val}, 1);
      check("stall_out_dat", {24'b0, out_dat}, 32'h23);
    end
    @(posedge clk); #1;
    out_rdy = 1'b1;
    send_byte(8'h23, 1'b0, dummy);
    check("resume_dat", {24'b0, out_dat}, 32'h21);
    send_byte(8'h24, 1'b0, dummy);
    drain();

    // 5-byte message with in_lst, followed by the first byte of the next message
    do_reset();
    kst_rdy = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'h31 + 8'(i), (i == 4), dummy);
    repeat (40) @(posedge clk);
    #1;
`ifdef QNIGMA_CHACHA20_XOR_BLK_ALIGN_EN
    // 2 words used + 14 discarded, plus the prefetch of the next block's word 0
    check("msg_reads", rd_cnt, 17);
    send_byte(8'h41, 1'b0, dummy);
    check("msg2_first", {24'b0, out_dat}, 32'h01);
`else
    check("msg_reads", rd_cnt, 2);
    send_byte(8'h41, 1'b0, dummy);
    check("msg2_first", {24'b0, out_dat}, 32'h44);
`endif
    drain();

    // Keystream stall in EMPTY, then reset while in WAIT
    do_reset();
    kst_rdy = 1'b1; out_rdy = 1'b1;
    send_byte(8'h51, 1'b0, dummy);
    send_byte(8'h52, 1'b0, dummy);
    send_byte(8'h53, 1'b0, dummy);
    drain();
    out_rdy = 1'b0; kst_rdy = 1'b0;
    send_byte(8'h54, 1'b0, dummy);
    in_val = 1'b1; in_dat = 8'h55;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("kst_stall_read",   {31'b0, kst_read}, 0);
      check("kst_stall_in_rdy", {31'b0, in_rdy}, 0);
      check("kst_stall_out",    {23'b0, out_val, out_dat}, 32'h157);
    end
    @(posedge clk); #1;
    kst_rdy = 1'b1;
    @(negedge clk);
    check("kst_resume_read", {31'b0, kst_read}, 1);
    @(posedge clk); #1;
    rst = 1'b1; kst_rdy = 1'b0; in_val = 1'b0;
    @(posedge clk); #1;
    check("wait_rst_outs", {28'b0, kst_read, in_rdy, out_val, out_lst}, 0);
    check("wait_rst_dat",  {24'b0, out_dat}, 0);
    rst = 1'b0;
    sb_q.delete();
    model_pos = 0;
    @(negedge clk);
    check("post_rst_in_rdy", {31'b0, in_rdy}, 0);
    @(posedge clk); #1;
    out_rdy = 1'b1; kst_rdy = 1'b1;
    send_byte(8'h66, 1'b0, dummy);
    check("realign_dat", {24'b0, out_dat}, 32'h66);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
